// File: rtl/pc_gen_unit.sv
// Fetch-stage next-PC generator: prioritised trap/jump/branch redirect,
// back-pressure, halt/resume and a circular return-address stack.
module pc_gen_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned    INST_BYTES   = 4,
  parameter int unsigned    RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_ready,
  output logic                         pc_valid,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus,
  input  logic                         br_taken,
  input  logic [XLEN-1:0]              br_target,
  input  logic                         jmp,
  input  logic [XLEN-1:0]              jmp_target,
  input  logic                         trap,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         halt,
  input  logic                         resume,
  input  logic                         call_hint,
  input  logic                         ret_hint,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign_err
);

  localparam int unsigned    PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned    CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ras_push, ras_pop, ras_repl;

  logic              fire, redir, tgt_mis;
  logic [XLEN-1:0]   redir_tgt, ras_top;

  assign pc_plus      = pc_q + XLEN'(INST_BYTES);
  assign pc           = pc_q;
  assign pc_valid     = (state_q == RUN);
  assign ras_count    = cnt_q;
  assign misalign_err = mis_q;

  assign fire      = (state_q == RUN) && fetch_ready;
  assign redir     = trap | jmp | br_taken;
  assign redir_tgt = trap ? trap_vector : (jmp ? jmp_target : br_target);
  assign tgt_mis   = |(redir_tgt & ALIGN_MASK);
  assign ras_top   = ras_mem[ptr_q - PTR_W'(1)];

  // State, pc and misalign flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state, next-pc and RAS control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mis_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_repl = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir) begin
          pc_d  = redir_tgt & ~ALIGN_MASK;
          mis_d = tgt_mis;
          if (halt) state_d = HALT;
        end else if (halt) begin
          state_d = HALT;
        end else if (fire) begin
          if (ret_hint && (cnt_q != '0)) begin
            pc_d     = ras_top;
            ras_repl = call_hint;
            ras_pop  = ~call_hint;
          end else begin
            pc_d     = pc_plus;
            ras_push = call_hint;
          end
        end
      end
      HALT: begin
        if (trap) begin
          pc_d    = redir_tgt & ~ALIGN_MASK;
          mis_d   = tgt_mis;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Circular return-address stack; when full a push overwrites the oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else if (ras_push) begin
      ras_mem[ptr_q] <= pc_plus;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
    end else if (ras_pop) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (ras_repl) begin
      ras_mem[ptr_q - PTR_W'(1)] <= pc_plus;
    end
  end

endmodule
